// File: rtl/slave_mem_pkg.sv
// Shared types and constants for the burst-capable bus-slave memory.
package slave_mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, DRAIN = 2'd2} state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int BE_WIDTH       = DEF_DATA_WIDTH / 8;
  localparam int RD_LAT_MIN     = 1;
  localparam int RD_LAT_MAX     = 2;

  // Sideband bits that travel down the read pipeline beside the RAM data.
  typedef struct packed {
    logic vld;
    logic last;
    logic err;
  } side_t;

  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/slave_memory_burst_if.sv
// Request/response bundle between the bus slave port controller and the memory.
interface slave_memory_burst_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic [LEN_WIDTH-1:0]    req_len;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    rsp_last;
  logic                    rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, req_len,
    input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, req_len,
    output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
  );
endinterface

// File: rtl/slave_mem_bytelane_ram.sv
// Single-port RAM built from independent byte lanes, read-first, with an
// optional output register and a matching sideband pipeline.
module slave_mem_bytelane_ram
  import slave_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 4096,
  parameter int READ_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       we,
  input  logic                       re,
  input  logic [DATA_WIDTH/8-1:0]    be,
  input  logic [$clog2(DEPTH)-1:0]   idx,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  side_t                      side_in,
  output logic [DATA_WIDTH-1:0]      rdata,
  output side_t                      side_out
);
  localparam int BE_W   = be_width(DATA_WIDTH);
  localparam int STAGES = (READ_LATENCY >= RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT_MIN;

  logic [DATA_WIDTH-1:0] rd_word;

  for (genvar b = 0; b < BE_W; b++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_q;
    always_ff @(posedge clk) begin
      if (we && be[b]) lane_mem[idx] <= wdata[8*b +: 8];
      if (re)          lane_q        <= lane_mem[idx];
    end
    assign rd_word[8*b +: 8] = lane_q;
  end

  if (STAGES == RD_LAT_MAX) begin : g_oreg
    logic [DATA_WIDTH-1:0] data_q;
    always_ff @(posedge clk) data_q <= rd_word;
    assign rdata = data_q;
  end else begin : g_noreg
    assign rdata = rd_word;
  end

  side_t pipe_q [STAGES];
  side_t pipe_d [STAGES];

  always_comb begin
    pipe_d[0] = side_in;
    for (int i = 1; i < STAGES; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (!rstn) pipe_q[i] <= '0;
      else       pipe_q[i] <= pipe_d[i];
    end
  end

  assign side_out = pipe_q[STAGES-1];
endmodule

// File: rtl/slave_memory_burst.sv
// Byte-enabled word memory with request/response handshake and a fixed-length
// incrementing read-burst engine; out-of-range beats return zero with err set.
module slave_memory_burst
  import slave_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_SIZE     = 4096,
  parameter int LEN_WIDTH    = 4,
  parameter int READ_LATENCY = 1
) (
  input logic                 clk,
  input logic                 rstn,
  slave_memory_burst_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_SIZE);
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;

  logic                  accept, in_range, ram_we, ram_re, issue_last;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  side_t                 side_in, side_out;

  assign accept = bus.req_valid && (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    len_d      = len_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = addr_q;
    issue_last = 1'b0;
    case (state_q)
      IDLE: begin
        ram_addr = bus.req_addr;
        if (accept) begin
          if (bus.req_write) begin
            ram_we = 1'b1;
          end else begin
            // Beat 0 goes to the RAM in the accepting cycle; the counter takes over.
            ram_re     = 1'b1;
            issue_last = (bus.req_len == '0);
            addr_d     = bus.req_addr + ADDR_WIDTH'(1);
            beat_d     = LEN_WIDTH'(1);
            len_d      = bus.req_len;
            state_d    = (bus.req_len == '0) ? DRAIN : BURST;
          end
        end
      end
      BURST: begin
        ram_re     = 1'b1;
        issue_last = (beat_q == len_q);
        addr_d     = addr_q + ADDR_WIDTH'(1);
        beat_d     = beat_q + LEN_WIDTH'(1);
        if (issue_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (side_out.vld && side_out.last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_range    = ({1'b0, ram_addr} < MEM_LIMIT);
  assign side_in.vld  = ram_re;
  assign side_in.last = issue_last;
  assign side_in.err  = ~in_range;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
    end
  end

  slave_mem_bytelane_ram #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH       (1 << IDX_W),
    .READ_LATENCY(READ_LATENCY)
  ) u_ram (
    .clk     (clk),
    .rstn    (rstn),
    .we      (ram_we && in_range),
    .re      (ram_re),
    .be      (bus.req_be),
    .idx     (ram_addr[IDX_W-1:0]),
    .wdata   (bus.req_wdata),
    .side_in (side_in),
    .rdata   (ram_rdata),
    .side_out(side_out)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = side_out.vld;
  assign bus.rsp_last  = side_out.vld & side_out.last;
  assign bus.rsp_err   = side_out.vld & side_out.err;
  assign bus.rsp_data  = (side_out.vld && !side_out.err) ? ram_rdata : '0;
endmodule

// File: tb/tb_slave_memory_burst.sv
// Directed bench: d1 (latency 1), d2 (latency 2) and d3 (latency 1, 2048 words)
// all receive the same request stream and are checked against hand values.
module tb_slave_memory_burst;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        drv_v, drv_w;
  logic [11:0] drv_a;
  logic [31:0] drv_d;
  logic [3:0]  drv_be, drv_len;

  slave_memory_burst_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .LEN_WIDTH(4)) if1 ();
  slave_memory_burst_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .LEN_WIDTH(4)) if2 ();
  slave_memory_burst_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .LEN_WIDTH(4)) if3 ();

  assign if1.req_valid = drv_v; assign if2.req_valid = drv_v; assign if3.req_valid = drv_v;
  assign if1.req_write = drv_w; assign if2.req_write = drv_w; assign if3.req_write = drv_w;
  assign if1.req_addr  = drv_a; assign if2.req_addr  = drv_a; assign if3.req_addr  = drv_a;
  assign if1.req_wdata = drv_d; assign if2.req_wdata = drv_d; assign if3.req_wdata = drv_d;
  assign if1.req_be    = drv_be; assign if2.req_be   = drv_be; assign if3.req_be   = drv_be;
  assign if1.req_len   = drv_len; assign if2.req_len = drv_len; assign if3.req_len = drv_len;

  slave_memory_burst #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_SIZE(4096), .LEN_WIDTH(4),
                       .READ_LATENCY(1)) d1 (.clk(clk), .rstn(rstn), .bus(if1));
  slave_memory_burst #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_SIZE(4096), .LEN_WIDTH(4),
                       .READ_LATENCY(2)) d2 (.clk(clk), .rstn(rstn), .bus(if2));
  slave_memory_burst #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_SIZE(2048), .LEN_WIDTH(4),
                       .READ_LATENCY(1)) d3 (.clk(clk), .rstn(rstn), .bus(if3));

  int ncmp = 0;
  int nerr = 0;

  logic [31:0] e1 [16];
  logic [31:0] e3 [16];
  logic [15:0] skip1, err3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
    drv_v = 1'b1; drv_w = 1'b1; drv_a = a; drv_d = d; drv_be = b;
    tick();
    drv_v = 1'b0; drv_w = 1'b0;
  endtask

  task automatic clr();
    for (int i = 0; i < 16; i++) begin e1[i] = '0; e3[i] = '0; end
    skip1 = '0; err3 = '0;
  endtask

  // Issue one read and check every cycle until both latency variants are idle.
  task automatic burst(input string tag, input logic [11:0] a, input int len);
    drv_v = 1'b1; drv_w = 1'b0; drv_a = a; drv_len = 4'(len);
    tick();
    drv_v = 1'b0;
    for (int c = 0; c <= len + 2; c++) begin
      if (c <= len) begin
        chk({tag, ".v1"}, 32'(if1.rsp_valid), 32'd1);
        chk({tag, ".last1"}, 32'(if1.rsp_last), 32'(c == len));
        chk({tag, ".err1"}, 32'(if1.rsp_err), 32'd0);
        chk({tag, ".rdy1"}, 32'(if1.req_ready), 32'd0);
        if (!skip1[c]) chk({tag, ".d1"}, if1.rsp_data, e1[c]);
        chk({tag, ".v3"}, 32'(if3.rsp_valid), 32'd1);
        chk({tag, ".err3"}, 32'(if3.rsp_err), 32'(err3[c]));
        chk({tag, ".d3"}, if3.rsp_data, e3[c]);
        chk({tag, ".last3"}, 32'(if3.rsp_last), 32'(c == len));
      end else if (c == len + 1) begin
        chk({tag, ".v1end"}, 32'(if1.rsp_valid), 32'd0);
        chk({tag, ".rdy1end"}, 32'(if1.req_ready), 32'd1);
        chk({tag, ".rdy2busy"}, 32'(if2.req_ready), 32'd0);
      end
      if (c >= 1 && c <= len + 1) begin
        chk({tag, ".v2"}, 32'(if2.rsp_valid), 32'd1);
        chk({tag, ".last2"}, 32'(if2.rsp_last), 32'(c - 1 == len));
        if (!skip1[c-1]) chk({tag, ".d2"}, if2.rsp_data, e1[c-1]);
      end else if (c == 0) begin
        chk({tag, ".v2early"}, 32'(if2.rsp_valid), 32'd0);
      end else begin
        chk({tag, ".rdy2end"}, 32'(if2.req_ready), 32'd1);
        chk({tag, ".v2end"}, 32'(if2.rsp_valid), 32'd0);
      end
      tick();
    end
  endtask

  initial begin
    rstn = 1'b0; drv_v = 1'b0; drv_w = 1'b0; drv_a = '0; drv_d = '0; drv_be = '0; drv_len = '0;
    tick(); tick();
    chk("rst.v1", 32'(if1.rsp_valid), 32'd0);
    chk("rst.d1", if1.rsp_data, 32'd0);
    chk("rst.rdy1", 32'(if1.req_ready), 32'd1);
    chk("rst.v2", 32'(if2.rsp_valid), 32'd0);
    chk("rst.last2", 32'(if2.rsp_last), 32'd0);
    rstn = 1'b1;
    tick();
    chk("post.rdy1", 32'(if1.req_ready), 32'd1);
    chk("post.rdy2", 32'(if2.req_ready), 32'd1);
    chk("post.err1", 32'(if1.rsp_err), 32'd0);

    // Byte-enable merge, read right after the write
    wr(12'h010, 32'hA5A5A5A5, 4'b1111);
    wr(12'h010, 32'h00000011, 4'b0001);
    clr(); e1[0] = 32'hA5A5A511; e3[0] = 32'hA5A5A511;
    burst("be", 12'h010, 0);

    // Eight-beat burst over a filled block
    for (int k = 0; k < 8; k++) wr(12'(k), 32'h01010101 * k, 4'b1111);
    clr();
    for (int k = 0; k < 8; k++) begin e1[k] = 32'h01010101 * k; e3[k] = e1[k]; end
    burst("b8", 12'h000, 7);

    // Range boundary on the 2048-word instance
    wr(12'h7FE, 32'h11111111, 4'b1111);
    wr(12'h7FF, 32'h22222222, 4'b1111);
    wr(12'h100, 32'h33333333, 4'b1111);
    wr(12'h900, 32'hDEADBEEF, 4'b1111);
    clr();
    e1[0] = 32'h11111111; e1[1] = 32'h22222222; skip1 = 16'b1100;
    e3[0] = 32'h11111111; e3[1] = 32'h22222222; err3  = 16'b1100;
    burst("rng", 12'h7FE, 3);
    clr(); e1[0] = 32'h33333333; e3[0] = 32'h33333333;
    burst("alias", 12'h100, 0);
    clr(); e1[0] = 32'hDEADBEEF; err3 = 16'b0001;
    burst("oor", 12'h900, 0);

    // Address wrap at the top of the 12-bit space
    wr(12'hFFE, 32'h0000FFFE, 4'b1111);
    wr(12'hFFF, 32'h0000FFFF, 4'b1111);
    clr();
    e1[0] = 32'h0000FFFE; e1[1] = 32'h0000FFFF; e1[2] = 32'h0; e1[3] = 32'h01010101;
    e3[3] = 32'h01010101; err3 = 16'b0011;
    burst("wrap", 12'hFFE, 3);

    // Reset in the middle of a burst
    drv_v = 1'b1; drv_w = 1'b0; drv_a = 12'h000; drv_len = 4'd7;
    tick();
    drv_v = 1'b0;
    tick(); tick();
    chk("mid.d1beat2", if1.rsp_data, 32'h02020202);
    chk("mid.d2beat1", if2.rsp_data, 32'h01010101);
    rstn = 1'b0;
    tick();
    chk("mid.v1", 32'(if1.rsp_valid), 32'd0);
    chk("mid.v2", 32'(if2.rsp_valid), 32'd0);
    chk("mid.d1", if1.rsp_data, 32'd0);
    rstn = 1'b1;
    tick();
    chk("mid.rdy1", 32'(if1.req_ready), 32'd1);
    chk("mid.rdy2", 32'(if2.req_ready), 32'd1);
    chk("mid.v1b", 32'(if1.rsp_valid), 32'd0);
    tick();
    chk("mid.v1c", 32'(if1.rsp_valid), 32'd0);
    chk("mid.v2c", 32'(if2.rsp_valid), 32'd0);
    clr(); e1[0] = 32'hA5A5A511; e3[0] = 32'hA5A5A511;
    burst("keep", 12'h010, 0);

    // Sixteen back-to-back writes, then a maximum-length burst
    drv_v = 1'b1; drv_w = 1'b1; drv_be = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      drv_a = 12'h020 + 12'(i);
      drv_d = 32'h11 * i;
      #1;
      chk("b2b.rdy1", 32'(if1.req_ready), 32'd1);
      chk("b2b.rdy2", 32'(if2.req_ready), 32'd1);
      tick();
    end
    drv_v = 1'b0; drv_w = 1'b0;
    clr();
    for (int i = 0; i < 16; i++) begin e1[i] = 32'h11 * i; e3[i] = e1[i]; end
    burst("b16", 12'h020, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/slave_memory_burst.md
Name: slave_memory_burst

Overview:
- Parametrised successor to the bus-slave memory.
- Word-wide, byte-enabled, inferred single-port RAM with a request/response handshake and a fixed-length incrementing read-burst engine.
- Configurable read latency (1 or 2) and out-of-range address detection.
- Sits behind the slave port controller of the system bus; replaces per-size vendor BRAM wrappers with one generic block.

Parameters:
- ADDR_WIDTH, 12, word address width.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- MEM_SIZE, 4096, number of words implemented; must be <= 2**ADDR_WIDTH.
- LEN_WIDTH, 4, burst length field width; bursts are 1..2**LEN_WIDTH beats.
- READ_LATENCY, 1, RAM-to-output latency; 1 or 2 (2 adds an output register).

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  start word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  DATA_WIDTH/8  byte enables (writes only).
- req_len  in  LEN_WIDTH  beats minus one (reads only; ignored on writes).
- rsp_valid  out  1  read beat valid.
- rsp_data  out  DATA_WIDTH  read beat data; 0 when rsp_valid=0.
- rsp_last  out  1  final beat of a burst.
- rsp_err  out  1  beat address was >= MEM_SIZE.

Behaviour:
- Interface: one clock, clk; reset rstn is synchronous and active-low.
- Reset (rstn=0 at a clk edge):
  - state <= IDLE; beat counter and read pipeline are flushed.
  - rsp_valid, rsp_last and rsp_err go to 0; rsp_data goes to 0.
  - req_ready=1 from the first cycle after reset.
  - RAM contents are not cleared.
  - A reset mid-burst aborts it; no further beats are emitted.
- Handshake: a request is accepted when req_valid && req_ready at a clk edge. No response backpressure; the master must sink every beat.
- Write (accepted at edge T):
  - RAM bytes i with req_be[i]=1 are updated at T; bytes with req_be[i]=0 are untouched.
  - State stays IDLE and req_ready stays 1, so back-to-back writes run one per cycle.
  - No write response is generated.
  - If addr >= MEM_SIZE, the write is dropped silently.
- Read (accepted at edge T):
  - Beat k (k = 0..req_len) reads address (req_addr + k) mod 2**ADDR_WIDTH.
  - Beat k is presented in cycle T+READ_LATENCY+k.
  - rsp_last=1 on beat req_len only.
  - Each beat whose address is >= MEM_SIZE returns data 0 with rsp_err=1; other beats have rsp_err=0.
  - A burst continues past out-of-range beats.
- FSM:
  - IDLE: req_ready=1.
    - Write accepted -> stay in IDLE.
    - Read accepted -> issue beat 0 to the RAM in the same cycle. Go to BURST if req_len>0, else to DRAIN.
  - BURST: req_ready=0. Issue one beat per cycle from a counter. When the last beat is issued -> DRAIN.
  - DRAIN: req_ready=0. Wait for the pipeline to empty, i.e. the cycle rsp_last=1 is presented. Then -> IDLE.
  - req_ready is first 1 again the cycle after rsp_last.
- Ordering: a read accepted the cycle after a write to the same address returns the new data. A single port means no same-cycle conflicts.
- Width rules:
  - Address increment truncates to ADDR_WIDTH.
  - The burst counter is LEN_WIDTH bits wide; maximum length 2**LEN_WIDTH beats.
  - The RAM index uses the low $clog2(MEM_SIZE) bits, qualified by the range check.

Decomposition:
- Shared package slave_mem_pkg holds:
  - FSM state encodings IDLE, BURST, DRAIN;
  - the localparam BE_WIDTH = DATA_WIDTH/8;
  - the legal READ_LATENCY values.
- Sub-module slave_mem_bytelane_ram:
  - inferred single-port RAM with per-byte write enables;
  - optional output register (READ_LATENCY=2);
  - pipelined valid/last/err sidebands alongside the data.
- The top level holds the FSM, burst counter, range check and output gating.

Test Plan:
- Reset then write addr 0x010 data 0xA5A5A5A5 be=1111, then write addr 0x010 data 0x00000011 be=0001, then read len=0 -> one beat 0xA5A5A511, rsp_last=1, rsp_err=0, at T+READ_LATENCY.
- Fill addr 0x000..0x007 with k*0x01010101, then read addr 0x000 len=7 -> 8 consecutive beats 0x00000000..0x07070707; rsp_last only on beat 7; req_ready=0 until the cycle after rsp_last.
- MEM_SIZE=2048: read addr 0x7FE len=3 -> beats 0x7FE and 0x7FF return stored data with rsp_err=0; beats 0x800 and 0x801 return 0 with rsp_err=1; a write to 0x900 does not alias onto 0x100.
- Read addr 0xFFE len=3 (MEM_SIZE=4096) -> addresses wrap 0xFFE, 0xFFF, 0x000, 0x001.
- Assert rstn=0 on the edge after beat 2 of a len=7 burst -> rsp_valid=0 from the next cycle, no further beats, req_ready=1 after reset; data written earlier is still readable.
- Back-to-back writes for 16 cycles with req_valid held high -> req_ready stays 1 throughout; repeat the whole suite with READ_LATENCY=2 and check every beat is shifted by one cycle.
